cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit for the 16-bit-instruction / 8-bit-datapath CPU.
- Fetches instructions over a req/ack instruction-memory port and decodes them.
- Sequences the ALU (ADD/SUB/AND/OR/XOR/NOT), register file and data-memory port through a fixed state machine.
- Owns PC, IR and the zero flag. Purely a sequencer: no data operands pass through it except imm8.

Parameters:
PC_W, 8, PC and memory address width (wraps at 2^PC_W).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching (level or pulse)
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch complete, imem_rdata valid this cycle
imem_rdata  in  16  instruction word
dmem_req  out  1  data-memory request
dmem_we  out  1  1 = store, 0 = load (valid with dmem_req)
dmem_addr  out  8  data address (= ir[7:0])
dmem_ack  in  1  data access complete
alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT
alu_zero  in  1  ALU result == 0
rf_ra  out  4  read port A = ir[7:4]
rf_rb  out  4  read port B = ir[11:8] for ST, else ir[3:0]
rf_wa  out  4  write address = ir[11:8]
rf_we  out  1  register write strobe, one cycle
wb_sel  out  2  00 ALU, 01 imm8, 10 dmem data
imm8  out  8  ir[7:0]
pc  out  PC_W  program counter
busy  out  1  state != IDLE and != HALT
halted  out  1  in HALT
illegal  out  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
Decided: one clock; reset is asynchronous and active-low.
- Opcode = ir[15:12]:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 NOT
  - 7 LDI; 8 LD; 9 ST; A JMP; B BEQ; F HALT; C–E illegal.
- Reset (async, any state): state=IDLE, pc=RESET_PC, ir=0, zero_flag=0, illegal=0. All strobes (imem_req, dmem_req, dmem_we, rf_we) and alu_op/wb_sel are 0. Any in-flight request is abandoned.
- IDLE: wait for start=1, then go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc, held until imem_ack.
  - On ack: ir<=imem_rdata, pc<=pc+1 (wraps all-ones→0), go to DECODE.
- DECODE (1 cycle):
  - ALU ops → EXEC. LDI → WB. LD/ST → MEM. NOP → FETCH. HALT → HALT.
  - JMP: pc<=imm8, go to FETCH.
  - BEQ: if zero_flag, pc<=imm8; go to FETCH.
  - Illegal: see Optional Feature.
- EXEC (1 cycle): alu_op driven from opcode; zero_flag<=alu_zero; go to WB.
- MEM:
  - dmem_req=1, dmem_we=(ST), held until dmem_ack.
  - On ack: LD → WB, ST → FETCH.
- WB (1 cycle): rf_we=1, wb_sel per op; go to FETCH. alu_op holds its EXEC value during WB.
- HALT: absorbing; halted=1; leave only via reset. start is ignored.
- imem_ack/dmem_ack asserted outside FETCH/MEM respectively are ignored.
- Ack in the same cycle as req assertion is legal (minimum 1-cycle access).
- Latencies with zero-wait memory (FETCH→…→FETCH): ALU op 4 cycles; LDI 3; LD 4; ST 3; NOP/JMP/BEQ 2.
- zero_flag updates only in EXEC; LD/LDI do not affect it.
- All outputs registered or decoded from state/ir only; no combinational path from imem_ack or dmem_ack to any output.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE sets illegal=1 (sticky until reset) and goes to HALT.
- Undefined: an illegal opcode is executed as NOP (→ FETCH); the illegal port is tied 0.

Test Plan:
1. Reset, start=1, imem returns 16'h5123 with zero-wait ack → alu_op=100 in EXEC, rf_we=1 with rf_wa=1, rf_ra=2, rf_rb=3, wb_sel=00 in WB; next fetch at addr 1 after 4 cycles.
2. LDI 16'h74A5 then ST 16'h9410, dmem_ack delayed 3 cycles → rf_we with wb_sel=01, imm8=A5; then dmem_req=1, dmem_we=1, dmem_addr=10, rf_rb=4 held 3 cycles; no rf_we for ST.
3. SUB producing alu_zero=1, then BEQ 16'hB040 → next imem_addr=40. Repeat with alu_zero=0 → next imem_addr=prev+1.
4. pc=FF, NOP fetched → pc wraps to 00. JMP 16'hA0FF → imem_addr=FF.
5. Opcode 16'hC000: with ILLEGAL_TRAP_EN → halted=1, illegal=1, no further imem_req. Without it → fetch continues, illegal=0. HALT 16'hF000 → halted=1, busy=0, start ignored.
6. Assert rst_n=0 mid-MEM with dmem_req=1 → dmem_req drops immediately (async), pc=RESET_PC, state IDLE. A late dmem_ack after reset has no effect.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_fsm
// Brief    : Multi-cycle fetch/decode/execute sequencer for the 16-bit ISA,
//            owning PC, IR and the zero flag. Optional macro: ILLEGAL_TRAP_EN.
// Revision : 1.0  initial release
// ============================================================================
module cpu_ctrl_fsm #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [7:0]      dmem_addr,
    input  logic            dmem_ack,
    output logic [2:0]      alu_op,
    input  logic            alu_zero,
    output logic [3:0]      rf_ra,
    output logic [3:0]      rf_rb,
    output logic [3:0]      rf_wa,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic [7:0]      imm8,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t          state, state_n;
    logic [PC_W-1:0] pc_n;
    logic [15:0]     ir, ir_n;
    logic            zero_flag, zero_n;
    logic [3:0]      opcode;
    logic            is_alu;
    logic            is_st;

    assign opcode = ir[15:12];
    assign is_alu = (opcode != OP_NOP) && (opcode <= OP_NOT);
    assign is_st  = (opcode == OP_ST);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_n;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= 16'h0000;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            zero_flag <= zero_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        zero_n  = zero_flag;
`ifdef ILLEGAL_TRAP_EN
        illegal_n = illegal_q;
`endif
        case (state)
            S_IDLE: if (start) state_n = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_n    = imem_rdata;
                    pc_n    = pc + PC_W'(1);
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: state_n = S_EXEC;
                    OP_LDI:        state_n = S_WB;
                    OP_LD, OP_ST:  state_n = S_MEM;
                    OP_HALT:       state_n = S_HALT;
                    OP_JMP: begin
                        pc_n    = PC_W'(ir[7:0]);
                        state_n = S_FETCH;
                    end
                    OP_BEQ: begin
                        if (zero_flag) pc_n = PC_W'(ir[7:0]);
                        state_n = S_FETCH;
                    end
`ifdef ILLEGAL_TRAP_EN
                    4'hC, 4'hD, 4'hE: begin
                        illegal_n = 1'b1;
                        state_n   = S_HALT;
                    end
`endif
                    default:       state_n = S_FETCH;
                endcase
            end
            S_EXEC: begin
                zero_n  = alu_zero;
                state_n = S_WB;
            end
            S_MEM: if (dmem_ack) state_n = is_st ? S_FETCH : S_WB;
            S_WB:   state_n = S_FETCH;
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    // Every output is a decode of state/ir so no ack-to-output path exists.
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = (state == S_MEM) && is_st;
    assign dmem_addr = ir[7:0];
    assign alu_op    = ((state == S_EXEC || state == S_WB) && is_alu) ?
                       3'(opcode - 4'd1) : 3'b000;
    assign rf_ra     = ir[7:4];
    assign rf_rb     = is_st ? ir[11:8] : ir[3:0];
    assign rf_wa     = ir[11:8];
    assign rf_we     = (state == S_WB);
    assign wb_sel    = (state != S_WB)      ? 2'b00 :
                       (opcode == OP_LDI)   ? 2'b01 :
                       (opcode == OP_LD)    ? 2'b10 : 2'b00;
    assign imm8      = ir[7:0];
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl_fsm
// Brief    : Randomized bench for cpu_ctrl_fsm; an instruction-level model
//            expands each instruction into its expected cycle sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl_fsm;

    localparam int         PC_W     = 8;
    localparam logic [7:0] RESET_PC = 8'h00;
    localparam int         DIR_N    = 10;
    localparam int         N_INSTR  = 600;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack = 1'b0;
    logic [15:0]     imem_rdata = 16'h0;
    logic            dmem_req, dmem_we;
    logic [7:0]      dmem_addr;
    logic            dmem_ack = 1'b0;
    logic [2:0]      alu_op;
    logic            alu_zero = 1'b0;
    logic [3:0]      rf_ra, rf_rb, rf_wa;
    logic            rf_we;
    logic [1:0]      wb_sel;
    logic [7:0]      imm8;
    logic [PC_W-1:0] pc;
    logic            busy, halted, illegal;

    cpu_ctrl_fsm #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_ack(dmem_ack), .alu_op(alu_op),
        .alu_zero(alu_zero), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa),
        .rf_we(rf_we), .wb_sel(wb_sel), .imm8(imm8), .pc(pc), .busy(busy),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // One expected cycle: inputs to drive plus the outputs that must appear.
    typedef struct {
        bit         start, ia, da, az;
        logic [15:0] rd;
        bit         ireq;
        logic [7:0] iaddr;
        bit         dreq, dwe;
        logic [7:0] daddr;
        bit         achk;
        logic [2:0] aop;
        bit         rfwe;
        logic [1:0] wsel;
        logic [3:0] wa, ra, rb;
        logic [7:0] im;
        bit         busy, halted, ill;
    } cyc_t;

    cyc_t exp_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_instr = 0;
    int   dir_idx = 0;

    logic [7:0] m_pc;
    bit         m_zero, m_halted, m_ill;

    logic [15:0] dir_instr[DIR_N] = '{16'h5123, 16'h74A5, 16'h9410, 16'h2000, 16'hB040,
                                      16'h2000, 16'hB040, 16'hA0FF, 16'h0000, 16'hC000};
    int          dir_dd[DIR_N]    = '{0, 0, 2, 0, 0, 0, 0, 0, 0, 0};
    bit          dir_z[DIR_N]     = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    int          fetch_n = 0;
    logic [7:0]  fetch_addr[DIR_N];
    int          fetch_cyc[DIR_N];
    int          rfw_n = 0;
    logic [3:0]  rfw_wa[2], rfw_ra[2], rfw_rb[2];
    logic [1:0]  rfw_sel[2];
    logic [2:0]  rfw_aop[2];
    logic [7:0]  rfw_im[2];
    int          st_cycles = 0;
    logic [7:0]  st_addr = 8'h00;
    logic [3:0]  st_rb = 4'h0;
    bit          st_we = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic cyc_t blank();
        cyc_t c;
        c.start  = 1'($urandom_range(0, 1));
        c.ia     = 1'($urandom_range(0, 1));
        c.da     = 1'($urandom_range(0, 1));
        c.az     = 1'($urandom_range(0, 1));
        c.rd     = 16'($urandom);
        c.ireq   = 1'b0; c.iaddr = 8'h00;
        c.dreq   = 1'b0; c.dwe = 1'b0; c.daddr = 8'h00;
        c.achk   = 1'b0; c.aop = 3'b000;
        c.rfwe   = 1'b0; c.wsel = 2'b00;
        c.wa     = 4'h0; c.ra = 4'h0; c.rb = 4'h0; c.im = 8'h00;
        c.busy   = 1'b1;
        c.halted = m_halted;
        c.ill    = m_ill;
        return c;
    endfunction

    task automatic push_idle();
        cyc_t c;
        int n = $urandom_range(0, 2);
        for (int i = 0; i <= n; i++) begin
            c = blank();
            c.busy  = 1'b0;
            c.start = (i == n);
            exp_q.push_back(c);
        end
    endtask

    // Expand one instruction into the cycles it must take, and retire it in the model.
    task automatic gen_instr(input logic [15:0] ins, input int idel, input int ddel, input bit zval);
        cyc_t c;
        logic [3:0] op = ins[15:12];
        bit is_alu = (op >= 4'h1 && op <= 4'h6);
        for (int i = 0; i <= idel; i++) begin
            c = blank();
            c.ireq = 1'b1; c.iaddr = m_pc;
            c.ia = (i == idel); c.rd = ins;
            exp_q.push_back(c);
        end
        m_pc = m_pc + 8'd1;
        exp_q.push_back(blank());
        c = blank();
        c.wa = ins[11:8]; c.ra = ins[7:4]; c.im = ins[7:0];
        c.rb = (op == 4'h9) ? ins[11:8] : ins[3:0];
        c.aop = 3'(op - 4'd1);
        if (is_alu) begin
            c.achk = 1'b1; c.az = zval;
            exp_q.push_back(c);
            m_zero = zval;
            c = blank();
            c.wa = ins[11:8]; c.ra = ins[7:4]; c.im = ins[7:0]; c.rb = ins[3:0];
            c.achk = 1'b1; c.aop = 3'(op - 4'd1);
            c.rfwe = 1'b1; c.wsel = 2'b00;
            exp_q.push_back(c);
        end else if (op == 4'h7) begin
            c.rfwe = 1'b1; c.wsel = 2'b01;
            exp_q.push_back(c);
        end else if (op == 4'h8 || op == 4'h9) begin
            for (int i = 0; i <= ddel; i++) begin
                cyc_t m = c;
                m.az = 1'($urandom_range(0, 1));
                m.dreq = 1'b1; m.dwe = (op == 4'h9); m.daddr = ins[7:0];
                m.da = (i == ddel);
                exp_q.push_back(m);
            end
            if (op == 4'h8) begin
                c = blank();
                c.wa = ins[11:8]; c.ra = ins[7:4]; c.im = ins[7:0]; c.rb = ins[3:0];
                c.rfwe = 1'b1; c.wsel = 2'b10;
                exp_q.push_back(c);
            end
        end else if (op == 4'hA) begin
            m_pc = ins[7:0];
        end else if (op == 4'hB) begin
            if (m_zero) m_pc = ins[7:0];
        end else if (op == 4'hF) begin
            m_halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        end else if (op >= 4'hC && op <= 4'hE) begin
            m_halted = 1'b1;
            m_ill    = 1'b1;
`endif
        end
        if (m_halted) begin
            int n = $urandom_range(2, 5);
            for (int i = 0; i < n; i++) begin
                c = blank();
                c.busy = 1'b0;
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic gen_next();
        if (dir_idx < DIR_N) begin
            gen_instr(dir_instr[dir_idx], 0, dir_dd[dir_idx], dir_z[dir_idx]);
            dir_idx++;
        end else begin
            gen_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end
        n_instr++;
    endtask

    // Asynchronous reset taken between edges, with stray acks while it is held.
    task automatic do_reset();
        #2;
        start = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_wb_sel", wb_sel, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        m_pc = RESET_PC; m_zero = 1'b0; m_halted = 1'b0; m_ill = 1'b0;
        exp_q.delete();
        push_idle();
    endtask

    task automatic compare(input cyc_t c);
        chk("busy", busy, c.busy);
        chk("halted", halted, c.halted);
        chk("illegal", illegal, c.ill);
        chk("imem_req", imem_req, c.ireq);
        if (c.ireq) chk("imem_addr", imem_addr, c.iaddr);
        chk("dmem_req", dmem_req, c.dreq);
        if (c.dreq) begin
            chk("dmem_we", dmem_we, c.dwe);
            chk("dmem_addr", dmem_addr, c.daddr);
            chk("mem_rf_rb", rf_rb, c.rb);
        end
        chk("rf_we", rf_we, c.rfwe);
        if (c.rfwe) begin
            chk("wb_sel", wb_sel, c.wsel);
            chk("rf_wa", rf_wa, c.wa);
            chk("rf_ra", rf_ra, c.ra);
            chk("rf_rb", rf_rb, c.rb);
            chk("imm8", imm8, c.im);
        end
        if (c.achk) chk("alu_op", alu_op, c.aop);
    endtask

    task automatic log_directed();
        if (imem_req && imem_ack && fetch_n < DIR_N) begin
            fetch_addr[fetch_n] = imem_addr;
            fetch_cyc[fetch_n]  = cyc;
            fetch_n++;
        end
        if (rf_we && rfw_n < 2) begin
            rfw_wa[rfw_n] = rf_wa; rfw_ra[rfw_n] = rf_ra; rfw_rb[rfw_n] = rf_rb;
            rfw_sel[rfw_n] = wb_sel; rfw_aop[rfw_n] = alu_op; rfw_im[rfw_n] = imm8;
            rfw_n++;
        end
        if (dmem_req && fetch_n == 3) begin
            if (st_cycles == 0) begin
                st_addr = dmem_addr; st_rb = rf_rb; st_we = dmem_we;
            end
            st_cycles++;
        end
    endtask

    initial begin
        cyc_t c;
        logic [7:0] exp_fa[DIR_N] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                      8'h40, 8'h41, 8'h42, 8'hFF, 8'h00};
        int exp_gap[DIR_N-1] = '{4, 3, 5, 4, 2, 4, 2, 2, 2};
        m_pc = RESET_PC; m_zero = 1'b0; m_halted = 1'b0; m_ill = 1'b0;
        do_reset();
        while (n_instr < N_INSTR) begin
            if (exp_q.size() == 0) begin
                if (m_halted) begin
                    do_reset();
                    continue;
                end
                gen_next();
            end
            c = exp_q.pop_front();
            @(posedge clk);
            #1;
            start = c.start; imem_ack = c.ia; imem_rdata = c.rd;
            dmem_ack = c.da; alu_zero = c.az;
            @(negedge clk);
            cyc++;
            compare(c);
            log_directed();
            if (c.dreq && n_instr > DIR_N + 5 && $urandom_range(0, 5) == 0) do_reset();
        end

        chk("dir_fetch_count", fetch_n, DIR_N);
        for (int i = 0; i < DIR_N; i++) chk("dir_fetch_addr", fetch_addr[i], exp_fa[i]);
        for (int i = 0; i < DIR_N - 1; i++)
            chk("dir_fetch_gap", fetch_cyc[i+1] - fetch_cyc[i], exp_gap[i]);
        chk("xor_rf_wa", rfw_wa[0], 4'h1);
        chk("xor_rf_ra", rfw_ra[0], 4'h2);
        chk("xor_rf_rb", rfw_rb[0], 4'h3);
        chk("xor_wb_sel", rfw_sel[0], 2'b00);
        chk("xor_alu_op", rfw_aop[0], 3'b100);
        chk("ldi_rf_wa", rfw_wa[1], 4'h4);
        chk("ldi_wb_sel", rfw_sel[1], 2'b01);
        chk("ldi_imm8", rfw_im[1], 8'hA5);
        chk("st_req_cycles", st_cycles, 3);
        chk("st_addr", st_addr, 8'h10);
        chk("st_rf_rb", st_rb, 4'h4);
        chk("st_we", st_we, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
